// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache sequencing controller and its arbiter.
package cache_pkg;

    localparam int ADDR_WIDTH_DEF = 6;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int SET_IDX_WIDTH  = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PROBE    = 3'd1,
        CHECK    = 3'd2,
        RAM_WAIT = 3'd3,
        FILL     = 3'd4,
        RESP     = 3'd5
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: a lone request is granted outright; on a tie the
// port not granted last wins. The pointer only moves when a grant is accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // last_q holds the port granted most recently; reset to 1 so port 0 wins first tie
    logic last_q;
    logic last_d;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Sequencing controller in front of a write-through cache: arbitrates two requesters,
// runs probe/check/RAM/fill/response cycles. Optional counters under CACHE_CTRL_STATS_EN.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
`ifdef CACHE_CTRL_STATS_EN
    , parameter int STAT_WIDTH = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_rdata,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_rdata,
    output logic                  cache_read_en,
    output logic                  cache_write_en,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic [DATA_WIDTH-1:0] cache_ram_data,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic                  ram_ack,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output state_e                dbg_state
`ifdef CACHE_CTRL_STATS_EN
    , output logic [STAT_WIDTH-1:0] stat_hits
    , output logic [STAT_WIDTH-1:0] stat_misses
    , output logic [STAT_WIDTH-1:0] stat_writes
`endif
);

    // Requester handshake: a request transfers on a cycle where reqN_valid && reqN_ready.
    // ready is high only in IDLE for the granted port; a waiting requester holds its inputs.
    state_e                state_q, state_d;
    logic                  port_q, port_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            grant;
    logic                  accept;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1_valid, req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    assign accept    = (state_q == IDLE) && (grant != 2'b00);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PROBE;
                    port_d  = grant[1];
                    we_d    = grant[1] ? req1_we    : req0_we;
                    addr_d  = grant[1] ? req1_addr  : req0_addr;
                    wdata_d = grant[1] ? req1_wdata : req0_wdata;
                    data_d  = '0;
                end
            end
            PROBE: state_d = CHECK;
            CHECK: begin
                // writes always go through to RAM and never allocate
                if (we_q) begin
                    state_d = RAM_WAIT;
                end else if (cache_hit) begin
                    data_d  = cache_rdata;
                    state_d = RESP;
                end else begin
                    state_d = RAM_WAIT;
                end
            end
            RAM_WAIT: begin
                if (ram_ack) begin
                    if (we_q) begin
                        state_d = RESP;
                    end else begin
                        data_d  = ram_rdata;
                        state_d = FILL;
                    end
                end
            end
            FILL:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        resp0_valid    = 1'b0;
        resp1_valid    = 1'b0;
        resp0_rdata    = '0;
        resp1_rdata    = '0;
        cache_read_en  = 1'b0;
        cache_write_en = 1'b0;
        cache_addr     = '0;
        cache_wdata    = '0;
        cache_ram_data = '0;
        ram_req        = 1'b0;
        ram_we         = 1'b0;
        ram_addr       = '0;
        ram_wdata      = '0;
        case (state_q)
            IDLE: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
            end
            PROBE: begin
                cache_addr     = addr_q;
                cache_write_en = we_q;
                cache_wdata    = we_q ? wdata_q : '0;
            end
            RAM_WAIT: begin
                ram_req   = 1'b1;
                ram_we    = we_q;
                ram_addr  = addr_q;
                ram_wdata = we_q ? wdata_q : '0;
            end
            FILL: begin
                cache_read_en  = 1'b1;
                cache_addr     = addr_q;
                cache_ram_data = data_q;
            end
            RESP: begin
                resp0_valid = !port_q;
                resp1_valid = port_q;
                resp0_rdata = port_q ? '0 : data_q;
                resp1_rdata = port_q ? data_q : '0;
            end
            default: ;
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [STAT_WIDTH-1:0] hits_q, hits_d;
    logic [STAT_WIDTH-1:0] misses_q, misses_d;
    logic [STAT_WIDTH-1:0] writes_q, writes_d;

    // each counter sticks at all-ones rather than wrapping
    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        writes_d = writes_q;
        if (state_q == CHECK) begin
            if (we_q) begin
                writes_d = (writes_q == '1) ? writes_q : writes_q + 1'b1;
            end else if (cache_hit) begin
                hits_d = (hits_q == '1) ? hits_q : hits_q + 1'b1;
            end else begin
                misses_d = (misses_q == '1) ? misses_q : misses_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
            writes_q <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
            writes_q <= writes_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
    assign stat_writes = writes_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: cache and RAM environment models plus a reference model of
// expected data, hit/miss outcome, latency and response port.
module tb_cache_ctrl;
    import cache_pkg::*;

    localparam int AW = 6;
    localparam int DW = 32;

`ifdef CACHE_CTRL_STATS_EN
    localparam int SW       = 2;
    localparam int STAT_MAX = (1 << SW) - 1;
    logic [SW-1:0] stat_hits, stat_misses, stat_writes;
    int ref_hits = 0, ref_misses = 0, ref_writes = 0;
`endif

    // ---------------- clock / reset and DUT signals
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_we = 1'b0, req1_we = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
    logic          req0_ready, req1_ready;
    logic          resp0_valid, resp1_valid;
    logic [DW-1:0] resp0_rdata, resp1_rdata;
    logic          cache_read_en, cache_write_en;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_wdata, cache_ram_data;
    logic          cache_hit = 1'b0;
    logic [DW-1:0] cache_rdata = '0;
    logic          ram_req, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_ack = 1'b0;
    logic [DW-1:0] ram_rdata = '0;
    state_e        dbg_state;

    cache_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
`ifdef CACHE_CTRL_STATS_EN
        , .STAT_WIDTH (SW)
`endif
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_we        (req0_we),
        .req0_addr      (req0_addr),
        .req0_wdata     (req0_wdata),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_we        (req1_we),
        .req1_addr      (req1_addr),
        .req1_wdata     (req1_wdata),
        .resp0_valid    (resp0_valid),
        .resp0_rdata    (resp0_rdata),
        .resp1_valid    (resp1_valid),
        .resp1_rdata    (resp1_rdata),
        .cache_read_en  (cache_read_en),
        .cache_write_en (cache_write_en),
        .cache_addr     (cache_addr),
        .cache_wdata    (cache_wdata),
        .cache_ram_data (cache_ram_data),
        .cache_hit      (cache_hit),
        .cache_rdata    (cache_rdata),
        .ram_req        (ram_req),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_ack        (ram_ack),
        .ram_rdata      (ram_rdata),
        .dbg_state      (dbg_state)
`ifdef CACHE_CTRL_STATS_EN
        , .stat_hits    (stat_hits)
        , .stat_misses  (stat_misses)
        , .stat_writes  (stat_writes)
`endif
    );

    // ---------------- cache model (registered lookup every cycle) and observation
    bit            cache_valid [64];
    bit [DW-1:0]   cache_data  [64];
    int            n_fill = 0, n_cwe = 0;
    logic [AW-1:0] last_fill_addr = '0, last_cwe_addr = '0;
    logic [DW-1:0] last_fill_data = '0, last_cwe_data = '0;

    always @(posedge clk) begin
        cache_hit   <= cache_valid[cache_addr];
        cache_rdata <= cache_data[cache_addr];
        if (cache_write_en) begin
            n_cwe         <= n_cwe + 1;
            last_cwe_addr <= cache_addr;
            last_cwe_data <= cache_wdata;
            if (cache_valid[cache_addr]) cache_data[cache_addr] <= cache_wdata;
        end
        if (cache_read_en) begin
            n_fill                 <= n_fill + 1;
            last_fill_addr         <= cache_addr;
            last_fill_data         <= cache_ram_data;
            cache_valid[cache_addr] <= 1'b1;
            cache_data[cache_addr]  <= cache_ram_data;
        end
    end

    // ---------------- RAM model: acks after ram_delay cycles of ram_req
    bit [DW-1:0]   ram_mem [64];
    int            ram_delay = 1;
    bit            stray_ack = 1'b0;
    int            ram_cnt = 0, n_ram = 0, ram_unstable = 0;
    logic          last_ram_we = 1'b0, hold_we = 1'b0;
    logic [AW-1:0] last_ram_addr = '0, hold_addr = '0;
    logic [DW-1:0] last_ram_wdata = '0, hold_wdata = '0;

    initial begin
        for (int i = 0; i < 64; i++) ram_mem[i] = $urandom;
        ram_mem[6'h15] = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            ram_ack = stray_ack;
            if (ram_req) begin
                ram_cnt++;
                if (ram_cnt == 1) begin
                    hold_we = ram_we; hold_addr = ram_addr; hold_wdata = ram_wdata;
                end else if (ram_we !== hold_we || ram_addr !== hold_addr || ram_wdata !== hold_wdata) begin
                    ram_unstable++;
                end
                if (ram_cnt >= ram_delay) begin
                    ram_ack        = 1'b1;
                    ram_rdata      = ram_mem[ram_addr];
                    if (ram_we) ram_mem[ram_addr] = ram_wdata;
                    n_ram++;
                    last_ram_we    = ram_we;
                    last_ram_addr  = ram_addr;
                    last_ram_wdata = ram_wdata;
                    ram_cnt        = 0;
                end
            end else begin
                ram_cnt = 0;
            end
        end
    end

    // ---------------- reference model and scoreboard
    bit [DW-1:0]   ref_mem    [64];
    bit            ref_cached [64];
    int            last_grant = 1;
    logic [DW-1:0] last_rd = '0;
    int            n_vec = 0, n_err = 0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(string tag);
        check({tag, "_ctl"}, {ram_req, ram_we, cache_read_en, cache_write_en,
                             resp0_valid, resp1_valid, req0_ready, req1_ready}, 64'd0);
        check({tag, "_addr"}, {ram_addr, cache_addr}, 64'd0);
        check({tag, "_wdata"}, {ram_wdata, cache_wdata}, 64'd0);
        check({tag, "_data"}, {cache_ram_data, resp0_rdata}, 64'd0);
        check({tag, "_rdata1"}, resp1_rdata, 64'd0);
        check({tag, "_state"}, dbg_state, IDLE);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 31));
    endfunction

    // polls from just after a negedge; on success the next posedge is the accept edge
    task automatic wait_accept(output int port, output bit ok);
        ok = 1'b0;
        port = -1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (req0_valid && req0_ready) begin port = 0; ok = 1'b1; break; end
            if (req1_valid && req1_ready) begin port = 1; ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // entered at the first negedge after the accept edge
    task automatic finish_txn(int port, bit we, logic [AW-1:0] addr, logic [DW-1:0] wdata);
        bit            exp_hit  = !we && ref_cached[addr];
        int            exp_lat  = we ? 3 + ram_delay : (exp_hit ? 3 : 4 + ram_delay);
        logic [DW-1:0] exp_data = we ? '0 : ref_mem[addr];
        int            ram0 = n_ram, fill0 = n_fill, cwe0 = n_cwe, unst0 = ram_unstable;
        int            lat = 0, wrong = 0;
        bit            got = 1'b0;
        logic [DW-1:0] rd = '0;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            if (port == 0 ? resp1_valid : resp0_valid) wrong++;
            if (port == 0 ? resp0_valid : resp1_valid) begin
                lat = k;
                rd  = (port == 0) ? resp0_rdata : resp1_rdata;
                got = 1'b1;
                break;
            end
        end
        last_rd = rd;
        check("resp_seen", got, 1);
        check("latency", lat, exp_lat);
        check("rdata", rd, exp_data);
        check("wrong_port_resp", wrong, 0);
        check("ram_txns", n_ram - ram0, exp_hit ? 0 : 1);
        check("fills", n_fill - fill0, (!we && !exp_hit) ? 1 : 0);
        check("cache_writes", n_cwe - cwe0, we ? 1 : 0);
        check("ram_stable", ram_unstable - unst0, 0);
        if (!exp_hit) check("ram_txn", {last_ram_we, last_ram_addr, we ? last_ram_wdata : 32'd0},
                            {we, addr, we ? wdata : 32'd0});
        if (!we && !exp_hit) check("fill_txn", {last_fill_addr, last_fill_data}, {addr, exp_data});
        if (we) check("probe_write", {last_cwe_addr, last_cwe_data}, {addr, wdata});
        @(negedge clk);
        #1;
        check("resp_single_pulse", {resp0_valid, resp1_valid}, 0);
`ifdef CACHE_CTRL_STATS_EN
        if (we) begin if (ref_writes < STAT_MAX) ref_writes++; end
        else if (exp_hit) begin if (ref_hits < STAT_MAX) ref_hits++; end
        else begin if (ref_misses < STAT_MAX) ref_misses++; end
`endif
        if (we) ref_mem[addr] = wdata;
        else if (!exp_hit) ref_cached[addr] = 1'b1;
    endtask

    task automatic do_req(int port, bit we, logic [AW-1:0] addr, logic [DW-1:0] wdata);
        int p;
        bit ok;
        @(negedge clk);
        if (port == 0) begin
            req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
        end else begin
            req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
        end
        wait_accept(p, ok);
        check("accept", ok, 1);
        check("grant_port", p, port);
        if (!ok) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        last_grant = p;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        finish_txn(port, we, addr, wdata);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed and random sequence
    initial begin
        int            p;
        bit            ok, seen;
        logic [AW-1:0] a;

        repeat (3) @(negedge clk);
        #1 check_quiet("reset");
        for (int i = 0; i < 64; i++) ref_mem[i] = ram_mem[i];
        @(negedge clk);
        rst_n = 1'b1;

        // read miss then hit at 0x15
        ram_delay = 2;
        do_req(0, 1'b0, 6'h15, '0);
        check("t1_fill_data", last_fill_data, 32'hDEADBEEF);
        check("t1_rdata", last_rd, 32'hDEADBEEF);
        do_req(0, 1'b0, 6'h15, '0);
        check("t1_hit_rdata", last_rd, 32'hDEADBEEF);

        // write-through then read back
        ram_delay = 1;
        do_req(1, 1'b1, 6'h15, 32'h12345678);
        check("t2_ram_write", {last_ram_we, last_ram_wdata}, {1'b1, 32'h12345678});
        do_req(0, 1'b0, 6'h15, '0);
        check("t2_hit_rdata", last_rd, 32'h12345678);
`ifdef CACHE_CTRL_STATS_EN
        check("stat_seq", {stat_hits, stat_misses, stat_writes}, {2'd2, 2'd1, 2'd1});
`endif

        // stray ack while idle
        @(negedge clk);
        @(posedge clk); #2 stray_ack = 1'b1;
        @(posedge clk); #2 stray_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 check_quiet("stray_ack");
        end

        // both ports requesting continuously
        @(negedge clk);
        req0_we = 1'b0; req0_addr = rand_addr(); req0_valid = 1'b1;
        req1_we = 1'b0; req1_addr = rand_addr(); req1_valid = 1'b1;
        for (int n = 0; n < 6; n++) begin
            wait_accept(p, ok);
            check("arb_accept", ok, 1);
            if (!ok) break;
            check("arb_grant", p, 1 - last_grant);
            last_grant = p;
            ram_delay = $urandom_range(1, 3);
            @(posedge clk);
            @(negedge clk);
            if (p == 0) begin a = req0_addr; req0_addr = rand_addr(); end
            else        begin a = req1_addr; req1_addr = rand_addr(); end
            finish_txn(p, 1'b0, a, '0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // random mix
        for (int n = 0; n < 40; n++) begin
            ram_delay = $urandom_range(1, 4);
            do_req($urandom_range(0, 1), ($urandom_range(0, 2) == 0), rand_addr(), $urandom);
        end
`ifdef CACHE_CTRL_STATS_EN
        check("stat_hits_sat", stat_hits, ref_hits);
        check("stat_misses_sat", stat_misses, ref_misses);
        check("stat_writes_sat", stat_writes, ref_writes);
`endif

        // reset during a RAM wait
        ram_delay = 30;
        @(negedge clk);
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'h3A;
        wait_accept(p, ok);
        check("rst_accept", ok, 1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (ram_req) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("rst_ram_req_seen", seen, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_quiet("mid_reset");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 check("reset_hold_quiet", {resp0_valid, resp1_valid, ram_req}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_grant = 1;
`ifdef CACHE_CTRL_STATS_EN
        ref_hits = 0; ref_misses = 0; ref_writes = 0;
`endif
        ram_delay = 2;
        do_req(0, 1'b0, 6'h3A, '0);
        do_req(1, 1'b0, 6'h3A, '0);
`ifdef CACHE_CTRL_STATS_EN
        check("stat_after_reset", {stat_hits, stat_misses, stat_writes}, {2'd1, 2'd1, 2'd0});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
